// File: rtl/mult_div_unit.sv
// -----------------------------------------------------------------------------
// mult_div_unit
//   HI/LO multiply/divide unit for the EX stage of a pipelined MIPS CPU.
//   A launch captures the full 64-bit result right away into a pending
//   register. A down-counter then keeps busy_o high for a fixed number of
//   cycles. HI/LO take the pending value on the same edge that busy_o falls,
//   so the hazard unit sees a fixed, predictable latency.
//
// Ports
//   clk_i        system clock, rising edge
//   reset_i      asynchronous active-high reset
//   start_i      one-cycle launch request (ignored while busy_o=1)
//   md_op_i[1:0] 00 MULT, 01 MULTU, 10 DIV, 11 DIVU
//   mthi_i       write rs_data_i into HI (only when idle and not starting)
//   mtlo_i       write rs_data_i into LO (only when idle and not starting)
//   rs_data_i    operand A: dividend / multiplicand / MTHI-MTLO source
//   rt_data_i    operand B: divisor / multiplier
//   busy_o       operation in flight
//   hi_o, lo_o   HI and LO registers
// -----------------------------------------------------------------------------
module mult_div_unit #(
   parameter int MULT_CYCLES = 5,
   parameter int DIV_CYCLES  = 10
) (
   input  logic        clk_i,
   input  logic        reset_i,
   input  logic        start_i,
   input  logic [1:0]  md_op_i,
   input  logic        mthi_i,
   input  logic        mtlo_i,
   input  logic [31:0] rs_data_i,
   input  logic [31:0] rt_data_i,
   output logic        busy_o,
   output logic [31:0] hi_o,
   output logic [31:0] lo_o
);

   localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
   localparam int CW         = $clog2(MAX_CYCLES + 1);

   logic [CW-1:0] cnt_q, cnt_d;
   logic          busy_q, busy_d;
   logic [31:0]   hi_q, hi_d;
   logic [31:0]   lo_q, lo_d;
   logic [31:0]   pend_hi_q, pend_hi_d;
   logic [31:0]   pend_lo_q, pend_lo_d;
   logic          pend_ok_q, pend_ok_d;   // cleared for divide-by-zero: commit leaves HI/LO alone

   // ---------------------------------------------------------------------
   // Result datapath (pure combinational on the launch operands)
   // ---------------------------------------------------------------------
   logic [63:0] prod_s, prod_u;
   logic        signed_div, a_neg, b_neg, b_zero;
   logic [31:0] a_mag, b_mag, q_mag, r_mag, div_q, div_r;
   logic [31:0] res_hi, res_lo;
   logic        res_ok;

   always_comb begin
      prod_s = $signed({{32{rs_data_i[31]}}, rs_data_i}) * $signed({{32{rt_data_i[31]}}, rt_data_i});
      prod_u = {32'd0, rs_data_i} * {32'd0, rt_data_i};

      // Signed division is done on magnitudes and then signed again. This
      // keeps 0x80000000 / -1 well defined: the magnitude quotient 0x80000000
      // passes through unchanged, because both operands are negative.
      signed_div = ~md_op_i[0];
      a_neg      = signed_div & rs_data_i[31];
      b_neg      = signed_div & rt_data_i[31];
      a_mag      = a_neg ? (32'd0 - rs_data_i) : rs_data_i;
      b_mag      = b_neg ? (32'd0 - rt_data_i) : rt_data_i;
      b_zero     = (rt_data_i == 32'd0);
      q_mag      = b_zero ? 32'd0 : (a_mag / b_mag);
      r_mag      = b_zero ? 32'd0 : (a_mag % b_mag);
      div_q      = (a_neg ^ b_neg) ? (32'd0 - q_mag) : q_mag;
      div_r      = a_neg ? (32'd0 - r_mag) : r_mag;   // remainder follows the dividend

      res_hi = div_r;
      res_lo = div_q;
      res_ok = ~b_zero;
      case (md_op_i)
         2'b00: begin res_hi = prod_s[63:32]; res_lo = prod_s[31:0]; res_ok = 1'b1; end
         2'b01: begin res_hi = prod_u[63:32]; res_lo = prod_u[31:0]; res_ok = 1'b1; end
         default: ;
      endcase
   end

   // ---------------------------------------------------------------------
   // Next-state logic
   // ---------------------------------------------------------------------
   always_comb begin
      cnt_d     = cnt_q;
      busy_d    = busy_q;
      hi_d      = hi_q;
      lo_d      = lo_q;
      pend_hi_d = pend_hi_q;
      pend_lo_d = pend_lo_q;
      pend_ok_d = pend_ok_q;

      if (busy_q) begin
         // start/mthi/mtlo are all ignored while an operation is in flight
         if (cnt_q == CW'(1)) begin
            cnt_d  = '0;
            busy_d = 1'b0;
            if (pend_ok_q) begin
               hi_d = pend_hi_q;
               lo_d = pend_lo_q;
            end
         end else begin
            cnt_d = cnt_q - CW'(1);
         end
      end else if (start_i) begin
         // start wins over a simultaneous MTHI/MTLO
         busy_d    = 1'b1;
         cnt_d     = md_op_i[1] ? CW'(DIV_CYCLES) : CW'(MULT_CYCLES);
         pend_hi_d = res_hi;
         pend_lo_d = res_lo;
         pend_ok_d = res_ok;
      end else begin
         if (mthi_i) hi_d = rs_data_i;
         if (mtlo_i) lo_d = rs_data_i;
      end
   end

   // ---------------------------------------------------------------------
   // State registers
   // ---------------------------------------------------------------------
   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         cnt_q     <= '0;
         busy_q    <= 1'b0;
         hi_q      <= '0;
         lo_q      <= '0;
         pend_hi_q <= '0;
         pend_lo_q <= '0;
         pend_ok_q <= 1'b0;
      end else begin
         cnt_q     <= cnt_d;
         busy_q    <= busy_d;
         hi_q      <= hi_d;
         lo_q      <= lo_d;
         pend_hi_q <= pend_hi_d;
         pend_lo_q <= pend_lo_d;
         pend_ok_q <= pend_ok_d;
      end
   end

   assign busy_o = busy_q;
   assign hi_o   = hi_q;
   assign lo_o   = lo_q;

endmodule

// File: tb/tb_mult_div_unit.sv
// -----------------------------------------------------------------------------
// tb_mult_div_unit
//   Self-checking bench for mult_div_unit: a table of known vectors, hand
//   sequences for reset, divide-by-zero and collisions, then randomized
//   operations checked against a 64-bit arithmetic reference model.
// -----------------------------------------------------------------------------
module tb_mult_div_unit;

   localparam int MC = 5;
   localparam int DC = 10;

   logic        clk = 1'b0;
   logic        reset;
   logic        start;
   logic [1:0]  md_op;
   logic        mthi, mtlo;
   logic [31:0] rs, rt;
   logic        busy_o;
   logic [31:0] hi_o, lo_o;

   int total = 0;
   int bad   = 0;
   logic [31:0] m_hi = 32'd0;   // model of HI/LO contents
   logic [31:0] m_lo = 32'd0;

   mult_div_unit #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
      .clk_i(clk), .reset_i(reset), .start_i(start), .md_op_i(md_op),
      .mthi_i(mthi), .mtlo_i(mtlo), .rs_data_i(rs), .rt_data_i(rt),
      .busy_o(busy_o), .hi_o(hi_o), .lo_o(lo_o)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [1:0]  op;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] exp_hi;
      logic [31:0] exp_lo;
   } vec_t;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
      end
   endtask

   // Reference model computed with plain 64-bit arithmetic
   function automatic void ref_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] h, output logic [31:0] l, output bit ok);
      longint          sa, sb, p;
      longint unsigned ua, ub, pu;
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      ua = {32'd0, a};
      ub = {32'd0, b};
      h = 32'd0; l = 32'd0; ok = 1'b1;
      case (op)
         2'd0: begin p = sa * sb; {h, l} = p; end
         2'd1: begin pu = ua * ub; {h, l} = pu; end
         2'd2: if (b == 32'd0) ok = 1'b0; else begin l = 32'(sa / sb); h = 32'(sa % sb); end
         default: if (b == 32'd0) ok = 1'b0; else begin l = 32'(ua / ub); h = 32'(ua % ub); end
      endcase
   endfunction

   // MTHI/MTLO write; called and returns at #1 after a rising edge
   task automatic mt(input logic wh, input logic wl, input logic [31:0] v);
      mthi = wh; mtlo = wl; rs = v;
      @(posedge clk); #1;
      mthi = 1'b0; mtlo = 1'b0;
      if (wh) m_hi = v;
      if (wl) m_lo = v;
      check("mt_hi", hi_o, m_hi);
      check("mt_lo", lo_o, m_lo);
      $display("mt  hi=%0b lo=%0b v=0x%08h -> hi=0x%08h lo=0x%08h", wh, wl, v, hi_o, lo_o);
   endtask

   // Launch one operation and follow it to commit. inject>0 pulses a competing
   // start on that busy cycle and mthi/mtlo on the next; both must be ignored.
   task automatic do_op(input string tag, input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic with_mthi, input int inject,
                        input logic [31:0] eh, input logic [31:0] el);
      int          n;
      int          cyc;
      logic        held;
      logic [31:0] h0, l0;
      n = op[1] ? DC : MC;
      cyc = 0;
      held = 1'b1;
      h0 = m_hi;
      l0 = m_lo;
      start = 1'b1; md_op = op; rs = a; rt = b; mthi = with_mthi;
      @(posedge clk); #1;
      start = 1'b0; mthi = 1'b0;
      while (busy_o && cyc < 40) begin
         cyc++;
         if (hi_o !== h0 || lo_o !== l0) held = 1'b0;
         if (cyc == inject) begin
            start = 1'b1; md_op = 2'b10; rs = 32'd100; rt = 32'd7;
         end else if (inject > 0 && cyc == inject + 1) begin
            start = 1'b0; mthi = 1'b1; mtlo = 1'b1; rs = 32'h999;
         end else begin
            start = 1'b0; mthi = 1'b0; mtlo = 1'b0;
         end
         @(posedge clk); #1;
      end
      start = 1'b0; mthi = 1'b0; mtlo = 1'b0;
      check({tag, "_busy_cycles"}, 32'(cyc), 32'(n));
      check({tag, "_hold"}, {31'd0, held}, 32'd1);
      check({tag, "_hi"}, hi_o, eh);
      check({tag, "_lo"}, lo_o, el);
      m_hi = eh;
      m_lo = el;
      $display("op %s md_op=%0d a=0x%08h b=0x%08h busy=%0d -> hi=0x%08h lo=0x%08h", tag, op, a, b, cyc, hi_o, lo_o);
   endtask

   vec_t vecs[8];

   initial begin
      vecs[0] = '{2'd0, 32'hFFFFFFFE, 32'd3,        32'hFFFFFFFF, 32'hFFFFFFFA};
      vecs[1] = '{2'd1, 32'hFFFFFFFE, 32'd3,        32'h00000002, 32'hFFFFFFFA};
      vecs[2] = '{2'd2, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD};
      vecs[3] = '{2'd3, 32'd7,        32'd2,        32'd1,        32'd3};
      vecs[4] = '{2'd2, 32'h80000000, 32'hFFFFFFFF, 32'd0,        32'h80000000};
      vecs[5] = '{2'd3, 32'hFFFFFFFF, 32'd16,       32'h0000000F, 32'h0FFFFFFF};
      vecs[6] = '{2'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001};
      vecs[7] = '{2'd2, 32'd7,        32'hFFFFFFFE, 32'd1,        32'hFFFFFFFD};

      reset = 1'b1; start = 1'b0; md_op = 2'd0; mthi = 1'b0; mtlo = 1'b0; rs = 32'd0; rt = 32'd0;
      repeat (2) @(posedge clk);
      #1;
      check("reset_busy", {31'd0, busy_o}, 32'd0);
      check("reset_hi", hi_o, 32'd0);
      check("reset_lo", lo_o, 32'd0);
      reset = 1'b0;
      @(posedge clk); #1;

      // Table of known vectors
      for (int i = 0; i < 8; i++)
         do_op($sformatf("vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].b, 1'b0, -1,
               vecs[i].exp_hi, vecs[i].exp_lo);

      // MTHI on an idle unit lands next cycle; both together write HI and LO
      mt(1'b1, 1'b0, 32'h5);
      mt(1'b1, 1'b1, 32'hCAFE0001);

      // Divide by zero keeps the prior HI/LO
      mt(1'b1, 1'b0, 32'h11);
      mt(1'b0, 1'b1, 32'h22);
      do_op("divzero", 2'd2, 32'd5, 32'd0, 1'b0, -1, 32'h11, 32'h22);
      do_op("divuzero", 2'd3, 32'hFFFF, 32'd0, 1'b0, -1, 32'h11, 32'h22);

      // start on busy cycle 2 (plus mthi/mtlo on cycle 3) are ignored
      do_op("collide", 2'd0, 32'hFFFFFFFE, 32'd3, 1'b0, 2, 32'hFFFFFFFF, 32'hFFFFFFFA);

      // mthi together with start: start wins, HI must not change at launch
      do_op("start_mthi", 2'd0, 32'd2, 32'd3, 1'b1, -1, 32'd0, 32'd6);

      // Asynchronous reset mid-MULT (counter at 3): clears at once, no later commit
      mt(1'b1, 1'b1, 32'h55);
      start = 1'b1; md_op = 2'd0; rs = 32'd3; rt = 32'd4;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (2) @(posedge clk);
      #3;
      reset = 1'b1;
      #1;
      check("midreset_busy", {31'd0, busy_o}, 32'd0);
      check("midreset_hi", hi_o, 32'd0);
      check("midreset_lo", lo_o, 32'd0);
      @(posedge clk); #1;
      reset = 1'b0;
      repeat (8) @(posedge clk);
      #1;
      check("postreset_busy", {31'd0, busy_o}, 32'd0);
      check("postreset_hi", hi_o, 32'd0);
      check("postreset_lo", lo_o, 32'd0);
      m_hi = 32'd0; m_lo = 32'd0;
      $display("reset mid-MULT -> busy=%0b hi=0x%08h lo=0x%08h", busy_o, hi_o, lo_o);

      // Randomized operations against the reference model
      for (int i = 0; i < 24; i++) begin
         logic [1:0]  op;
         logic [31:0] a, b, eh, el;
         bit          ok;
         op = 2'($urandom_range(0, 3));
         a  = $urandom;
         case ($urandom_range(0, 5))
            0:       b = 32'd0;
            1:       b = 32'($urandom_range(1, 9));
            2:       b = 32'hFFFFFFFF;
            default: b = $urandom;
         endcase
         if ($urandom_range(0, 4) == 0) a = 32'h80000000;
         ref_op(op, a, b, eh, el, ok);
         if (!ok) begin eh = m_hi; el = m_lo; end
         do_op($sformatf("rnd%0d", i), op, a, b, 1'b0, -1, eh, el);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
